vga_fb_arbiter: RTL and testbench

//  Shares the single-port frame-buffer RAM between the VGA scanout fetch and host
//  (Arduino command interface) pixel writes. Scanout reads always win; host writes
//  are buffered in a small FIFO and retired in idle slots. Also runs a hardware

---
 rtl/vga_gpu_pkg.sv | 29 ++
 rtl/fb_wr_fifo.sv | 51 +++++
 rtl/vga_fb_arbiter.sv | 152 +++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_gpu_pkg.sv
// Shared types and defaults for the VGA frame-buffer arbitration path.
package vga_gpu_pkg;

    localparam int DEF_ADDR_W      = 12;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_WFIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_CLEAR = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_READ  = 2'd1,
        GNT_CLEAR = 2'd2,
        GNT_FIFO  = 2'd3
    } grant_t;

    // Fixed slot priority: scanout read, then clear fill, then queued host write.
    function automatic grant_t pick_grant(input logic rd, input logic clr, input logic fifo);
        if (rd)        return GNT_READ;
        else if (clr)  return GNT_CLEAR;
        else if (fifo) return GNT_FIFO;
        else           return GNT_NONE;
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO holding host frame-buffer writes until a free RAM slot appears.
module fb_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic [W-1:0] store [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign level    = wr_ptr - rd_ptr;
    assign pop_data = store[rd_ptr[PW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: payload storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Arbitrates the single-port frame-buffer RAM between scanout reads, buffered host
// writes and a hardware clear-screen fill.
module vga_fb_arbiter
    import vga_gpu_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WFIFO_DEPTH = DEF_WFIFO_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            disp_rd_req,
    input  logic [ADDR_W-1:0]               disp_rd_addr,
    output logic                            disp_rd_valid,
    output logic [DATA_W-1:0]               disp_rd_data,
    input  logic                            host_wr_valid,
    output logic                            host_wr_ready,
    input  logic [ADDR_W-1:0]               host_wr_addr,
    input  logic [DATA_W-1:0]               host_wr_data,
    input  logic                            clear_req,
    input  logic [DATA_W-1:0]               clear_value,
    output logic                            clear_busy,
    output logic                            mem_en,
    output logic                            mem_we,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    input  logic [DATA_W-1:0]               mem_rdata,
    output logic [$clog2(WFIFO_DEPTH):0]    fifo_level
);

    localparam int LVL_W = $clog2(WFIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    arb_state_t          state;
    grant_t              gnt;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]   clr_val;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                rd_valid_q;

    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;
    logic [LVL_W-1:0]    level_nxt;
    logic                fifo_empty_nxt;

    assign host_wr_ready = !fifo_full && (state == S_RUN);
    assign push          = host_wr_valid && host_wr_ready;
    assign pop           = (gnt == GNT_FIFO);
    assign clear_busy    = (state != S_RUN);
    assign disp_rd_valid = rd_valid_q;
    assign disp_rd_data  = mem_rdata;

    // State decisions look at the occupancy after this cycle's push/pop.
    assign level_nxt      = fifo_level + LVL_W'(push) - LVL_W'(pop);
    assign fifo_empty_nxt = (level_nxt == '0);

    fb_wr_fifo #(
        .DEPTH (WFIFO_DEPTH),
        .W     (ADDR_W + DATA_W)
    ) u_wr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({host_wr_addr, host_wr_data}),
        .pop       (pop),
        .pop_data  ({head_addr, head_data}),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Gated by rst_n so the RAM sees no strobe while reset is held.
    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        gnt       = GNT_NONE;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (rst_n) gnt = pick_grant(disp_rd_req, state == S_CLEAR, !fifo_empty);
        case (gnt)
            GNT_READ: begin
                mem_en   = 1'b1;
                mem_addr = disp_rd_addr;
            end
            GNT_CLEAR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = clr_cnt;
                mem_wdata = clr_val;
            end
            GNT_FIFO: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = head_addr;
                mem_wdata = head_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= (gnt == GNT_READ);
            if (mem_en) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_RUN;
            clr_cnt <= '0;
            clr_val <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (clear_req) begin
                        clr_val <= clear_value;
                        state   <= fifo_empty_nxt ? S_CLEAR : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty_nxt) state <= S_CLEAR;
                end
                S_CLEAR: begin
                    if (gnt == GNT_CLEAR) begin
                        if (clr_cnt == LAST_ADDR) begin
                            clr_cnt <= '0;
                            state   <= S_RUN;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: behavioural RAM, write-queue scoreboard,
// directed scenarios plus a randomized traffic phase.
module tb_vga_fb_arbiter;

    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 3;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          disp_rd_req = 1'b0;
    logic [AW-1:0] disp_rd_addr = '0;
    logic          disp_rd_valid;
    logic [DW-1:0] disp_rd_data;
    logic          host_wr_valid = 1'b0;
    logic          host_wr_ready;
    logic [AW-1:0] host_wr_addr = '0;
    logic [DW-1:0] host_wr_data = '0;
    logic          clear_req = 1'b0;
    logic [DW-1:0] clear_value = '0;
    logic          clear_busy;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [LW-1:0] fifo_level;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0]      ram  [WORDS];
    logic [DW-1:0]      gold [WORDS];
    logic [AW+DW-1:0]   q [$];
    logic [DW-1:0]      clr5_val;

    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WFIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .disp_rd_req   (disp_rd_req),
        .disp_rd_addr  (disp_rd_addr),
        .disp_rd_valid (disp_rd_valid),
        .disp_rd_data  (disp_rd_data),
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_wr_addr  (host_wr_addr),
        .host_wr_data  (host_wr_data),
        .clear_req     (clear_req),
        .clear_value   (clear_value),
        .clear_busy    (clear_busy),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .fifo_level    (fifo_level)
    );

    always #20 clk = ~clk;

    // Single-port RAM model: read data appears the cycle after the read strobe.
    initial begin : ram_model
        for (int i = 0; i < WORDS; i++) ram[i] = DW'($urandom);
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) ram[mem_addr] = mem_wdata;
                else        mem_rdata <= ram[mem_addr];
            end
        end
    end

    // Advance one clock; a read requested this cycle must return next cycle with the RAM word.
    task automatic tick();
        logic          exp_v;
        logic [DW-1:0] exp_d;
        exp_v = disp_rd_req && rst_n;
        exp_d = ram[disp_rd_addr];
        @(posedge clk);
        #1;
        if (rst_n) begin
            vectors++;
            if (disp_rd_valid !== exp_v) begin
                miscompares++;
                $display("FAIL rd_valid: got %0b want %0b", disp_rd_valid, exp_v);
            end
            if (exp_v) begin
                vectors++;
                if (disp_rd_data !== exp_d) begin
                    miscompares++;
                    $display("FAIL rd_data: got %h want %h", disp_rd_data, exp_d);
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, disp_rd_valid, clear_busy, fifo_level} !== '0
            || host_wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: got en=%0b we=%0b addr=%h wd=%h vld=%0b busy=%0b lvl=%0d rdy=%0b want all 0, rdy=1",
                     tag, mem_en, mem_we, mem_addr, mem_wdata, disp_rd_valid, clear_busy, fifo_level, host_wr_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        disp_rd_req = 1'b1;
        disp_rd_addr = AW'($urandom);
        host_wr_valid = 1'b1;
        clear_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        disp_rd_req = 1'b0;
        host_wr_valid = 1'b0;
        clear_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_idle_read();
        disp_rd_req = 1'b1;
        disp_rd_addr = 12'h010;
        @(negedge clk);
        vectors++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h010) begin
            miscompares++;
            $display("FAIL idle_read_slot: got en=%0b we=%0b addr=%h want 1 0 010", mem_en, mem_we, mem_addr);
        end
        tick();
        disp_rd_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (mem_en !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_slot: got en=%0b want 0", mem_en);
        end
        tick();
    endtask

    task automatic test_fifo_fill();
        disp_rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            disp_rd_addr  = AW'($urandom);
            host_wr_valid = 1'b1;
            host_wr_addr  = AW'(12'h100 + i);
            host_wr_data  = DW'(8'hA0 + i);
            @(negedge clk);
            vectors++;
            if (host_wr_ready !== 1'b1 || mem_we !== 1'b0) begin
                miscompares++;
                $display("FAIL fill_accept[%0d]: got rdy=%0b we=%0b want 1 0", i, host_wr_ready, mem_we);
            end
            tick();
        end
        host_wr_valid = 1'b0;
        disp_rd_addr = AW'($urandom);
        @(negedge clk);
        vectors++;
        if (fifo_level !== LW'(4) || host_wr_ready !== 1'b0 || mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: got lvl=%0d rdy=%0b we=%0b want 4 0 0", fifo_level, host_wr_ready, mem_we);
        end
        tick();
        disp_rd_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(12'h100 + i)
                || mem_wdata !== DW'(8'hA0 + i) || fifo_level !== LW'(4 - i)) begin
                miscompares++;
                $display("FAIL fill_retire[%0d]: got en=%0b we=%0b addr=%h data=%h lvl=%0d want 1 1 %h %h %0d",
                         i, mem_en, mem_we, mem_addr, mem_wdata, fifo_level, 12'h100 + i, 8'hA0 + i, 4 - i);
            end
            tick();
        end
        @(negedge clk);
        vectors++;
        if (fifo_level !== '0 || mem_en !== 1'b0 || host_wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_empty: got lvl=%0d en=%0b rdy=%0b want 0 0 1", fifo_level, mem_en, host_wr_ready);
        end
        tick();
    endtask

    task automatic test_push_pop();
        logic [AW+DW-1:0] e [3];
        for (int i = 0; i < 3; i++) e[i] = (AW+DW)'($urandom);
        disp_rd_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            host_wr_valid = 1'b1;
            {host_wr_addr, host_wr_data} = e[i];
            tick();
        end
        disp_rd_req = 1'b0;
        {host_wr_addr, host_wr_data} = e[2];
        @(negedge clk);
        vectors++;
        if (fifo_level !== LW'(2) || host_wr_ready !== 1'b1 || mem_we !== 1'b1 || {mem_addr, mem_wdata} !== e[0]) begin
            miscompares++;
            $display("FAIL pp_same_cycle: got lvl=%0d rdy=%0b we=%0b word=%h want 2 1 1 %h",
                     fifo_level, host_wr_ready, mem_we, {mem_addr, mem_wdata}, e[0]);
        end
        tick();
        host_wr_valid = 1'b0;
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (fifo_level !== LW'(3 - i) || mem_we !== 1'b1 || {mem_addr, mem_wdata} !== e[i]) begin
                miscompares++;
                $display("FAIL pp_order[%0d]: got lvl=%0d we=%0b word=%h want %0d 1 %h",
                         i, fifo_level, mem_we, {mem_addr, mem_wdata}, 3 - i, e[i]);
            end
            tick();
        end
    endtask

    task automatic test_clear_drain();
        logic [AW+DW-1:0] e [2];
        int drained = 0;
        int caddr = 0;
        int bad = 0;
        bit done = 1'b0;
        for (int i = 0; i < 2; i++) e[i] = (AW+DW)'($urandom);
        disp_rd_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            host_wr_valid = 1'b1;
            {host_wr_addr, host_wr_data} = e[i];
            tick();
        end
        host_wr_valid = 1'b0;
        clear_req = 1'b1;
        clear_value = 8'h3F;
        tick();
        clear_req = 1'b0;
        clear_value = 8'hC0;
        disp_rd_req = 1'b0;
        for (int c = 0; c < 5000 && !done; c++) begin
            @(negedge clk);
            if (!clear_busy) begin
                done = 1'b1;
            end else begin
                vectors++;
                if (host_wr_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL clr_ready_low: got %0b want 0", host_wr_ready);
                end
                if (mem_en && mem_we) begin
                    vectors++;
                    if (drained < 2) begin
                        if ({mem_addr, mem_wdata} !== e[drained]) begin
                            miscompares++;
                            $display("FAIL clr_drain[%0d]: got %h want %h", drained, {mem_addr, mem_wdata}, e[drained]);
                        end
                        drained++;
                    end else begin
                        if (mem_addr !== AW'(caddr) || mem_wdata !== 8'h3F || caddr >= WORDS) begin
                            miscompares++;
                            $display("FAIL clr_write: got addr=%h data=%h want %h 3f", mem_addr, mem_wdata, caddr);
                        end
                        caddr++;
                    end
                end
                tick();
            end
        end
        vectors++;
        if (!done || drained != 2 || caddr != WORDS || host_wr_ready !== 1'b1 || fifo_level !== '0) begin
            miscompares++;
            $display("FAIL clr_end: got done=%0b drained=%0d writes=%0d rdy=%0b lvl=%0d want 1 2 4096 1 0",
                     done, drained, caddr, host_wr_ready, fifo_level);
        end
        for (int i = 0; i < WORDS; i++) if (ram[i] !== 8'h3F) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL clr_image: got %0d words not 3f want 0", bad);
        end
        tick();
    endtask

    task automatic test_clear_with_reads();
        int caddr = 0;
        int bad = 0;
        bit done = 1'b0;
        do clr5_val = DW'($urandom); while (clr5_val == 8'h15 || clr5_val == 8'h3F);
        clear_req = 1'b1;
        clear_value = clr5_val;
        @(negedge clk);
        vectors++;
        if (mem_en !== 1'b0 || clear_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL clr5_accept: got en=%0b busy=%0b want 0 0", mem_en, clear_busy);
        end
        tick();
        clear_req = 1'b0;
        for (int c = 0; c < 10000 && !done; c++) begin
            disp_rd_req = (c % 2 == 0);
            disp_rd_addr = AW'($urandom);
            @(negedge clk);
            if (!clear_busy) begin
                done = 1'b1;
            end else begin
                vectors++;
                if (disp_rd_req) begin
                    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== disp_rd_addr) begin
                        miscompares++;
                        $display("FAIL clr5_read: got en=%0b we=%0b addr=%h want 1 0 %h", mem_en, mem_we, mem_addr, disp_rd_addr);
                    end
                end else begin
                    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(caddr) || mem_wdata !== clr5_val || caddr >= WORDS) begin
                        miscompares++;
                        $display("FAIL clr5_write: got en=%0b we=%0b addr=%h data=%h want 1 1 %h %h",
                                 mem_en, mem_we, mem_addr, mem_wdata, caddr, clr5_val);
                    end
                    caddr++;
                end
                tick();
            end
        end
        disp_rd_req = 1'b0;
        vectors++;
        if (!done || caddr != WORDS) begin
            miscompares++;
            $display("FAIL clr5_count: got done=%0b writes=%0d want 1 4096", done, caddr);
        end
        for (int i = 0; i < WORDS; i++) if (ram[i] !== clr5_val) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL clr5_image: got %0d words wrong want 0", bad);
        end
        tick();
    endtask

    task automatic test_reset_mid_clear();
        bit hit = 1'b0;
        disp_rd_req = 1'b0;
        clear_req = 1'b1;
        clear_value = 8'h15;
        tick();
        clear_req = 1'b0;
        for (int c = 0; c < 1000 && !hit; c++) begin
            @(negedge clk);
            if (mem_en && mem_we && mem_addr == 12'h200) hit = 1'b1;
            else tick();
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL rst_reach_200: got no write to 200 want one within 1000 cycles");
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid_clear");
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (clear_busy !== 1'b0 || fifo_level !== '0 || mem_en !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_after_release: got busy=%0b lvl=%0d en=%0b want 0 0 0", clear_busy, fifo_level, mem_en);
        end
        vectors++;
        if (ram[12'h1FF] !== 8'h15 || ram[12'h200] !== clr5_val) begin
            miscompares++;
            $display("FAIL rst_partial: got 1ff=%h 200=%h want 15 %h", ram[12'h1FF], ram[12'h200], clr5_val);
        end
        tick();
        disp_rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_wr_valid = 1'b1;
            host_wr_addr = AW'($urandom);
            host_wr_data = DW'($urandom);
            tick();
        end
        host_wr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_fifo_discard");
        tick();
        disp_rd_req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (mem_en !== 1'b0 || fifo_level !== '0) begin
            miscompares++;
            $display("FAIL rst_no_stale: got en=%0b lvl=%0d want 0 0", mem_en, fifo_level);
        end
        tick();
    endtask

    task automatic rand_cycle(input bit traffic);
        int n;
        bit exp_wr;
        disp_rd_req   = traffic && ($urandom_range(0, 99) < 55);
        disp_rd_addr  = AW'($urandom);
        host_wr_valid = traffic && $urandom_range(0, 1) == 1;
        host_wr_addr  = AW'($urandom);
        host_wr_data  = DW'($urandom);
        @(negedge clk);
        n = q.size();
        exp_wr = !disp_rd_req && n > 0;
        vectors++;
        if (fifo_level !== LW'(n) || host_wr_ready !== (n < DEPTH) || mem_en !== (disp_rd_req || exp_wr) || mem_we !== exp_wr) begin
            miscompares++;
            $display("FAIL rnd_slot: got lvl=%0d rdy=%0b en=%0b we=%0b want %0d %0b %0b %0b",
                     fifo_level, host_wr_ready, mem_en, mem_we, n, n < DEPTH, disp_rd_req || exp_wr, exp_wr);
        end
        if (disp_rd_req) begin
            vectors++;
            if (mem_addr !== disp_rd_addr) begin
                miscompares++;
                $display("FAIL rnd_rd_addr: got %h want %h", mem_addr, disp_rd_addr);
            end
        end
        if (exp_wr) begin
            vectors++;
            if ({mem_addr, mem_wdata} !== q[0]) begin
                miscompares++;
                $display("FAIL rnd_wr_word: got %h want %h", {mem_addr, mem_wdata}, q[0]);
            end
            void'(q.pop_front());
        end
        if (host_wr_valid && n < DEPTH) begin
            q.push_back({host_wr_addr, host_wr_data});
            gold[host_wr_addr] = host_wr_data;
        end
        tick();
    endtask

    task automatic test_random();
        int bad = 0;
        q.delete();
        for (int i = 0; i < WORDS; i++) gold[i] = ram[i];
        for (int c = 0; c < 600; c++) rand_cycle(1'b1);
        for (int c = 0; c < 10 && q.size() != 0; c++) rand_cycle(1'b0);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL rnd_drain: got %0d pending want 0", q.size());
        end
        for (int i = 0; i < WORDS; i++) if (ram[i] !== gold[i]) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL rnd_image: got %0d words differ want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_idle_read();
        test_fifo_fill();
        test_push_pop();
        test_clear_drain();
        test_clear_with_reads();
        test_reset_mid_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
